moonbase_io_bridge: RTL and testbench

Downstream bus stage for moonbase_cpu_4bit. It takes the CPU's multiplexed 8-bit io_out bus and holds the 7-bit address latch. It drives the external 256-nibble SRAM with separate code and data halves. It also implements the device space: a 16-bit GPIO output, 8 GPIO inputs and a prescaled 8-bit countdown timer. Its 2-bit device read data goes back to the CPU's io_in[7:6], and SRAM read data passes through to io_in[5:2].

---
 rtl/moonbase_io_bridge.sv | 130 +++++++++++++
 tb/tb_moonbase_io_bridge.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/moonbase_io_bridge.sv
// moonbase_io_bridge: downstream bus stage for moonbase_cpu_4bit.
// Latches the 7-bit address from the CPU's multiplexed io_out, drives the
// external 256-nibble SRAM (code/data halves), and provides the device space:
// a 16-bit GPIO output, 8 GPIO inputs and a prescaled 8-bit countdown timer.
// Ports:
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   cpu_bus         : CPU io_out ([7]=strobe; address or {code, ram_we_n, dev_we_n, data})
//   cpu_ram_in      : SRAM read data back to CPU io_in[5:2]
//   cpu_dev_in      : device read data back to CPU io_in[7:6]
//   sram_addr/wdata/we_n/rdata : external SRAM interface
//   gpio_out, gpio_in : GPIO ports
//   timer_irq       : timer expired flag
module moonbase_io_bridge #(
    parameter int PRESCALE = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  cpu_bus,
    output logic [3:0]  cpu_ram_in,
    output logic [1:0]  cpu_dev_in,
    output logic [7:0]  sram_addr,
    output logic [3:0]  sram_wdata,
    output logic        sram_we_n,
    input  logic [3:0]  sram_rdata,
    output logic [15:0] gpio_out,
    input  logic [7:0]  gpio_in,
    output logic        timer_irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [6:0]    addr;
    logic          code;
    logic [3:0]    tmr_lo;
    logic [7:0]    count;
    logic          running;
    logic          expired;
    logic [PW-1:0] prescaler;

    logic       strobe;
    logic       dev_we;
    logic [3:0] data;
    logic [7:0] load_val;
    logic       tmr_load;
    logic       tmr_clear;
    logic       wrap;
    logic       expire;

    assign strobe = cpu_bus[7];
    assign data   = cpu_bus[3:0];
    assign dev_we = !strobe && !cpu_bus[4];

    assign load_val  = {data, tmr_lo};
    assign tmr_load  = dev_we && (addr[2:0] == 3'd5);
    assign tmr_clear = dev_we && (addr[2:0] == 3'd6);
    assign wrap      = (prescaler == PRESC_LAST);
    // A reload on the decrement edge suppresses the decrement, and with it any expiry.
    assign expire    = running && wrap && (count == 8'd1) && !tmr_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            code      <= 1'b0;
            gpio_out  <= '0;
            tmr_lo    <= '0;
            count     <= '0;
            running   <= 1'b0;
            expired   <= 1'b0;
            prescaler <= '0;
        end else begin
            if (strobe)
                addr <= cpu_bus[6:0];
            else
                code <= cpu_bus[6];

            if (dev_we) begin
                case (addr[2:0])
                    3'd0:    gpio_out[3:0]   <= data;
                    3'd1:    gpio_out[7:4]   <= data;
                    3'd2:    gpio_out[11:8]  <= data;
                    3'd3:    gpio_out[15:12] <= data;
                    3'd4:    tmr_lo          <= data;
                    default: ;
                endcase
            end

            if (tmr_load) begin
                count     <= load_val;
                running   <= (load_val != 8'd0);
                prescaler <= '0;
            end else if (running) begin
                if (wrap) begin
                    prescaler <= '0;
                    count     <= count - 8'd1;
                    if (count == 8'd1)
                        running <= 1'b0;
                end else begin
                    prescaler <= prescaler + PW'(1);
                end
            end

            // Expiry wins over a same-cycle clear so an interrupt is never lost.
            if (expire)
                expired <= 1'b1;
            else if (tmr_clear)
                expired <= 1'b0;
        end
    end

    always_comb begin
        cpu_dev_in = 2'b00;
        case (addr[2:0])
            3'd0:    cpu_dev_in = gpio_in[1:0];
            3'd1:    cpu_dev_in = gpio_in[3:2];
            3'd2:    cpu_dev_in = gpio_in[5:4];
            3'd3:    cpu_dev_in = gpio_in[7:6];
            3'd4:    cpu_dev_in = {expired, running};
            3'd5:    cpu_dev_in = count[7:6];
            default: cpu_dev_in = 2'b00;
        endcase
    end

    assign sram_addr  = {code, addr};
    assign sram_wdata = cpu_bus[3:0];
    assign sram_we_n  = !(!strobe && !cpu_bus[5]);
    assign cpu_ram_in = sram_rdata;
    assign timer_irq  = expired;

endmodule

// File: tb/tb_moonbase_io_bridge.sv
// Testbench for moonbase_io_bridge (PRESCALE=4): vector table, hand-written
// timer sequences, then randomized traffic against a behavioural model.
module tb_moonbase_io_bridge;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cpu_bus;
    logic [3:0]  cpu_ram_in;
    logic [1:0]  cpu_dev_in;
    logic [7:0]  sram_addr;
    logic [3:0]  sram_wdata;
    logic        sram_we_n;
    logic [3:0]  sram_rdata;
    logic [15:0] gpio_out;
    logic [7:0]  gpio_in;
    logic        timer_irq;

    moonbase_io_bridge #(.PRESCALE(P)) dut (
        .clk(clk), .reset(reset), .cpu_bus(cpu_bus),
        .cpu_ram_in(cpu_ram_in), .cpu_dev_in(cpu_dev_in),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we_n(sram_we_n),
        .sram_rdata(sram_rdata), .gpio_out(gpio_out), .gpio_in(gpio_in),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [7:0] b);
        cpu_bus = b;
        @(posedge clk);
        #1;
    endtask

    // Strobe address a, then a device write of d (SRAM write disabled).
    task automatic dev_write(input logic [2:0] a, input logic [3:0] d);
        cyc({5'b10000, a});
        cyc({4'b0010, d});
    endtask

    typedef struct {
        logic [7:0]  bus;
        logic [15:0] e_gpio;
        logic [1:0]  e_dev;
        logic [7:0]  e_addr;
        logic        e_we_n;
    } vec_t;

    vec_t vt[11];

    // Behavioural model: timer described as elapsed clocks since load.
    logic [6:0]  m_addr;
    logic        m_code;
    logic [15:0] m_gpio;
    logic [3:0]  m_lo;
    int          m_load, m_el;
    logic        m_run, m_exp;

    task automatic m_reset();
        m_addr = '0; m_code = 0; m_gpio = '0; m_lo = '0;
        m_load = 0; m_el = 0; m_run = 0; m_exp = 0;
    endtask

    function automatic int m_count();
        return m_run ? (m_load - m_el / P) : 0;
    endfunction

    function automatic logic [1:0] m_dev();
        int c;
        c = m_count();
        case (m_addr[2:0])
            3'd0: return gpio_in[1:0];
            3'd1: return gpio_in[3:2];
            3'd2: return gpio_in[5:4];
            3'd3: return gpio_in[7:6];
            3'd4: return {m_exp, m_run};
            3'd5: return c[7:6];
            default: return 2'b00;
        endcase
    endfunction

    task automatic m_edge(input logic [7:0] b);
        logic       wr, expire_now;
        logic [2:0] a;
        logic [3:0] d;
        wr = !b[7] && !b[4];
        a = m_addr[2:0];
        d = b[3:0];
        expire_now = 0;
        if (wr && a == 3'd5) begin
            m_load = {d, m_lo};
            m_el = 0;
            m_run = (m_load != 0);
        end else if (m_run) begin
            m_el++;
            if (m_el == m_load * P) begin
                m_run = 0;
                m_exp = 1;
                expire_now = 1;
            end
        end
        if (wr) begin
            if (a < 3'd4) m_gpio[a*4 +: 4] = d;
            else if (a == 3'd4) m_lo = d;
            else if (a == 3'd6 && !expire_now) m_exp = 0;
        end
        if (b[7]) m_addr = b[6:0];
        else m_code = b[6];
    endtask

    initial begin
        vt[0]  = '{8'hA3, 16'h0000, 2'd0, 8'h00, 1'b1};
        vt[1]  = '{8'h1C, 16'h0000, 2'd3, 8'h23, 1'b0};
        vt[2]  = '{8'h82, 16'h0000, 2'd3, 8'h23, 1'b1};
        vt[3]  = '{8'h27, 16'h0000, 2'd2, 8'h02, 1'b1};
        vt[4]  = '{8'h8A, 16'h0700, 2'd2, 8'h02, 1'b1};
        vt[5]  = '{8'h29, 16'h0700, 2'd2, 8'h0A, 1'b1};
        vt[6]  = '{8'h80, 16'h0900, 2'd2, 8'h0A, 1'b1};
        vt[7]  = '{8'h81, 16'h0900, 2'd0, 8'h00, 1'b1};
        vt[8]  = '{8'h82, 16'h0900, 2'd1, 8'h01, 1'b1};
        vt[9]  = '{8'h83, 16'h0900, 2'd2, 8'h02, 1'b1};
        vt[10] = '{8'h84, 16'h0900, 2'd3, 8'h03, 1'b1};

        // Reset state
        reset = 1; cpu_bus = 8'h30; gpio_in = 8'hA5; sram_rdata = 4'h6;
        #12;
        chk("rst_gpio", gpio_out, 0);
        chk("rst_irq", timer_irq, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_dev", cpu_dev_in, 2'b01);
        chk("rst_ram_in", cpu_ram_in, 4'h6);
        @(negedge clk) reset = 0;
        @(posedge clk); #1;

        // Vector table: address, SRAM path, GPIO write/alias, GPIO read
        gpio_in = 8'b11_10_01_00;
        for (int i = 0; i < 11; i++) begin
            cpu_bus = vt[i].bus;
            sram_rdata = 4'($urandom);
            @(negedge clk);
            chk($sformatf("vec%0d_gpio", i), gpio_out, vt[i].e_gpio);
            chk($sformatf("vec%0d_dev", i), cpu_dev_in, vt[i].e_dev);
            chk($sformatf("vec%0d_addr", i), sram_addr, vt[i].e_addr);
            chk($sformatf("vec%0d_we_n", i), sram_we_n, vt[i].e_we_n);
            chk($sformatf("vec%0d_wdata", i), sram_wdata, vt[i].bus[3:0]);
            chk($sformatf("vec%0d_ram_in", i), cpu_ram_in, sram_rdata);
            @(posedge clk); #1;
        end

        // Timer: load 3, expiry exactly 12 clocks after the load edge
        dev_write(3'd4, 4'h3);
        dev_write(3'd5, 4'h0);
        for (int i = 1; i <= 12; i++) begin
            cyc(8'h84);
            chk($sformatf("tmr_irq_edge%0d", i), timer_irq, (i == 12) ? 1 : 0);
            if (i == 1) chk("tmr_running", cpu_dev_in, 2'b01);
        end
        chk("tmr_status_expired", cpu_dev_in, 2'b10);

        // Load 0: starts nothing, expired stays set
        dev_write(3'd4, 4'h0);
        dev_write(3'd5, 4'h0);
        cyc(8'h84);
        chk("load0_status", cpu_dev_in, 2'b10);
        chk("load0_irq", timer_irq, 1);

        dev_write(3'd6, 4'h5);
        chk("clear_irq", timer_irq, 0);

        // Reload on the decrement edge wins and restarts the prescaler
        dev_write(3'd4, 4'h0);
        dev_write(3'd5, 4'h4);
        for (int i = 0; i < 3; i++) cyc(8'h30);
        cyc(8'h28);
        chk("reload_count", cpu_dev_in, 2'b10);
        for (int i = 0; i < 3; i++) begin
            cyc(8'h30);
            chk($sformatf("reload_hold%0d", i), cpu_dev_in, 2'b10);
        end
        cyc(8'h30);
        chk("reload_dec", cpu_dev_in, 2'b01);

        // Reset mid-count
        reset = 1;
        #1;
        chk("midrst_irq", timer_irq, 0);
        chk("midrst_gpio", gpio_out, 0);
        chk("midrst_addr", sram_addr, 0);
        @(negedge clk) reset = 0;
        cyc(8'h85);
        cyc(8'h84);
        chk("midrst_count", cpu_dev_in, 2'b00);
        cyc(8'h30);
        chk("midrst_running", cpu_dev_in, 2'b00);

        // Randomized traffic against the model
        reset = 1; #1; m_reset();
        @(negedge clk) reset = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            if (i == 1500) begin
                reset = 1; #1; m_reset();
                @(negedge clk) reset = 0;
            end
            b = 8'($urandom);
            b[7] = ($urandom_range(0, 99) < 35);
            if (!b[7] && !b[4] && m_addr[2:0] == 3'd5)
                b[3:0] = 4'($urandom_range(0, 1));
            cpu_bus = b;
            gpio_in = 8'($urandom);
            sram_rdata = 4'($urandom);
            @(negedge clk);
            chk("rnd_addr", sram_addr, {m_code, m_addr});
            chk("rnd_we_n", sram_we_n, !(!b[7] && !b[5]));
            chk("rnd_wdata", sram_wdata, b[3:0]);
            chk("rnd_ram_in", cpu_ram_in, sram_rdata);
            chk("rnd_gpio", gpio_out, m_gpio);
            chk("rnd_irq", timer_irq, m_exp);
            chk("rnd_dev", cpu_dev_in, m_dev());
            @(posedge clk);
            m_edge(b);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
